game_history_stack: RTL

GAME_HISTORY_STACK -- requirements
Module: game_history_stack

---
 rtl/game_history_stack.sv | 76 +++++++
 1 files changed

// File: rtl/game_history_stack.sv
// Undo history for the game core: a LIFO of pre-move game states kept in a
// circular buffer. When the buffer is full a new push overwrites the oldest
// entry, so the most recent DEPTH moves can always be retracted.
module game_history_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 134
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               state_in,
    input  logic                       pop,
    output logic [W-1:0]               state_out,
    output logic                       state_out_valid,
    output logic                       real_retract,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] top_ptr;
    logic          has_entry;
    logic          do_pop;
    logic          do_push;

    // Top of stack sits just below the next free slot; wraps with the pointer.
    assign top_ptr   = wr_ptr - PTR_ONE;
    assign has_entry = (count != '0);

    // Clear beats everything; a pop in the same cycle as a push drops the push.
    assign do_pop  = !clear && pop && has_entry;
    assign do_push = !clear && push && !pop;

    assign real_retract = has_entry;
    assign full         = (count == CNT_FULL);

    // Entry storage: never reset or cleared, the count alone says what is live.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= state_in;
    end

    // Pointer, occupancy and popped-entry register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            count           <= '0;
            state_out       <= '0;
            state_out_valid <= 1'b0;
        end else begin
            state_out_valid <= do_pop;
            if (clear) begin
                wr_ptr <= '0;
                count  <= '0;
            end else if (do_pop) begin
                state_out <= mem[top_ptr];
                wr_ptr    <= top_ptr;
                count     <= count - CNT_ONE;
            end else if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                // Full push overwrites the oldest slot; occupancy saturates.
                if (!full)
                    count <= count + CNT_ONE;
            end
        end
    end

endmodule
